axi4_bram_arbiter: RTL

- Two-master to one-slave arbiter for the AXI4 block-RAM port (32-bit address, 8-bit len, INCR bursts, no IDs).
- Lets the UART bridge and a second master, for example a DMA or test engine, share one BRAM controller.
- Write path (AW/W/B) and read path (AR/R) are arbitrated independently, so one read and one write can be in flight at the same time.
- A grant is held for the whole burst, including its response.

---
 rtl/axi4_bram_arbiter.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_bram_arbiter.sv
// axi4_bram_arbiter: two AXI4 masters sharing one BRAM slave port.
// Write (AW/W/B) and read (AR/R) paths are arbitrated by independent FSMs.
// Each grant is held from the address phase through the burst's last response.
// Optional build macro ARB_FIXED_PRIO_EN: master 0 always wins simultaneous
// requests. When it is undefined, the arbiter uses round-robin.
module axi4_bram_arbiter #(
   parameter int unsigned A_WIDTH    = 32,
   parameter int unsigned BYTE_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   // master write address
   input  logic [1:0]                  m_awvalid,
   output logic [1:0]                  m_awready,
   input  logic [2*A_WIDTH-1:0]        m_awaddr,
   input  logic [15:0]                 m_awlen,
   // master write data
   input  logic [1:0]                  m_wvalid,
   output logic [1:0]                  m_wready,
   input  logic [1:0]                  m_wlast,
   input  logic [2*8*BYTE_WIDTH-1:0]   m_wdata,
   // master write response
   output logic [1:0]                  m_bvalid,
   input  logic [1:0]                  m_bready,
   output logic [3:0]                  m_bresp,
   // master read address
   input  logic [1:0]                  m_arvalid,
   output logic [1:0]                  m_arready,
   input  logic [2*A_WIDTH-1:0]        m_araddr,
   input  logic [15:0]                 m_arlen,
   // master read data
   output logic [1:0]                  m_rvalid,
   input  logic [1:0]                  m_rready,
   output logic [1:0]                  m_rlast,
   output logic [2*8*BYTE_WIDTH-1:0]   m_rdata,
   // slave write address
   output logic                        s_awvalid,
   input  logic                        s_awready,
   output logic [A_WIDTH-1:0]          s_awaddr,
   output logic [7:0]                  s_awlen,
   // slave write data
   output logic                        s_wvalid,
   input  logic                        s_wready,
   output logic                        s_wlast,
   output logic [8*BYTE_WIDTH-1:0]     s_wdata,
   // slave write response
   input  logic                        s_bvalid,
   output logic                        s_bready,
   input  logic [1:0]                  s_bresp,
   // slave read address
   output logic                        s_arvalid,
   input  logic                        s_arready,
   output logic [A_WIDTH-1:0]          s_araddr,
   output logic [7:0]                  s_arlen,
   // slave read data
   input  logic                        s_rvalid,
   output logic                        s_rready,
   input  logic                        s_rlast,
   input  logic [8*BYTE_WIDTH-1:0]     s_rdata,
   // status
   output logic [1:0]                  wr_owner,
   output logic [1:0]                  rd_owner,
   output logic                        prot_err
);

   localparam int unsigned D_WIDTH = 8 * BYTE_WIDTH;
   localparam int unsigned L_WIDTH = 8;

   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;

   wr_state_t            r_wr_state, w_wr_nxt;
   rd_state_t            r_rd_state, w_rd_nxt;
   logic                 r_wr_gnt, r_rd_gnt;
   logic [L_WIDTH-1:0]   r_awlen;
   logic [L_WIDTH-1:0]   r_beat_cnt;
   logic                 r_prot_err;
   logic                 w_wr_pick, w_rd_pick;
   logic                 w_aw_hs, w_w_hs, w_b_hs;
   logic                 w_wlast_loc, w_wlast_sel;
   logic [A_WIDTH-1:0]   w_awaddr_sel, w_araddr_sel;
   logic [L_WIDTH-1:0]   w_awlen_sel, w_arlen_sel;
   logic [D_WIDTH-1:0]   w_wdata_sel;

   // Granted-master channel selection
   assign w_awaddr_sel = r_wr_gnt ? m_awaddr[2*A_WIDTH-1:A_WIDTH] : m_awaddr[A_WIDTH-1:0];
   assign w_awlen_sel  = r_wr_gnt ? m_awlen[15:8]                 : m_awlen[7:0];
   assign w_wdata_sel  = r_wr_gnt ? m_wdata[2*D_WIDTH-1:D_WIDTH]  : m_wdata[D_WIDTH-1:0];
   assign w_wlast_sel  = r_wr_gnt ? m_wlast[1]                    : m_wlast[0];
   assign w_araddr_sel = r_rd_gnt ? m_araddr[2*A_WIDTH-1:A_WIDTH] : m_araddr[A_WIDTH-1:0];
   assign w_arlen_sel  = r_rd_gnt ? m_arlen[15:8]                 : m_arlen[7:0];
   assign w_wlast_loc  = (r_beat_cnt == r_awlen);
   assign prot_err     = r_prot_err;

`ifdef ARB_FIXED_PRIO_EN
   // Master 0 wins whenever it requests
   assign w_wr_pick = ~m_awvalid[0];
   assign w_rd_pick = ~m_arvalid[0];
`else
   logic r_rr_wr, r_rr_rd;

   // Pointer decides ties; a sole requester always wins
   assign w_wr_pick = (&m_awvalid) ? r_rr_wr : m_awvalid[1];
   assign w_rd_pick = (&m_arvalid) ? r_rr_rd : m_arvalid[1];

   // Round-robin pointers favour the master that did not just finish
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_wr <= 1'b0;
         r_rr_rd <= 1'b0;
      end else begin
         if (w_b_hs)
            r_rr_wr <= ~r_wr_gnt;
         if (r_rd_state == R_DATA && s_rvalid && m_rready[r_rd_gnt] && s_rlast)
            r_rr_rd <= ~r_rd_gnt;
      end
   end
`endif

   // Write FSM state, grant, burst length, beat count and protocol check
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_state <= W_IDLE;
         r_wr_gnt   <= 1'b0;
         r_awlen    <= '0;
         r_beat_cnt <= '0;
         r_prot_err <= 1'b0;
      end else begin
         r_wr_state <= w_wr_nxt;
         if (r_wr_state == W_IDLE && |m_awvalid)
            r_wr_gnt <= w_wr_pick;
         if (w_aw_hs) begin
            r_awlen    <= w_awlen_sel;
            r_beat_cnt <= '0;
         end
         if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + L_WIDTH'(1);
            if (w_wlast_sel != w_wlast_loc)
               r_prot_err <= 1'b1;
         end
      end
   end

   // Write FSM next state and channel muxing
   always_comb begin
      w_wr_nxt  = r_wr_state;
      w_aw_hs   = 1'b0;
      w_w_hs    = 1'b0;
      w_b_hs    = 1'b0;
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_awlen   = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wlast   = 1'b0;
      s_bready  = 1'b0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      wr_owner  = '0;
      case (r_wr_state)
         W_IDLE: begin
            if (|m_awvalid)
               w_wr_nxt = W_AW;
         end
         W_AW: begin
            wr_owner[r_wr_gnt]  = 1'b1;
            s_awvalid           = m_awvalid[r_wr_gnt];
            s_awaddr            = w_awaddr_sel;
            s_awlen             = w_awlen_sel;
            m_awready[r_wr_gnt] = s_awready;
            if (m_awvalid[r_wr_gnt] && s_awready) begin
               w_aw_hs  = 1'b1;
               w_wr_nxt = W_DATA;
            end
         end
         W_DATA: begin
            wr_owner[r_wr_gnt] = 1'b1;
            s_wvalid           = m_wvalid[r_wr_gnt];
            s_wdata            = w_wdata_sel;
            s_wlast            = w_wlast_loc;
            m_wready[r_wr_gnt] = s_wready;
            if (m_wvalid[r_wr_gnt] && s_wready) begin
               w_w_hs = 1'b1;
               if (w_wlast_loc)
                  w_wr_nxt = W_RESP;
            end
         end
         W_RESP: begin
            wr_owner[r_wr_gnt] = 1'b1;
            m_bvalid[r_wr_gnt] = s_bvalid;
            if (r_wr_gnt)
               m_bresp[3:2] = s_bresp;
            else
               m_bresp[1:0] = s_bresp;
            s_bready = m_bready[r_wr_gnt];
            if (s_bvalid && m_bready[r_wr_gnt]) begin
               w_b_hs   = 1'b1;
               w_wr_nxt = W_IDLE;
            end
         end
         default: w_wr_nxt = W_IDLE;
      endcase
   end

   // Read FSM state and grant
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_state <= R_IDLE;
         r_rd_gnt   <= 1'b0;
      end else begin
         r_rd_state <= w_rd_nxt;
         if (r_rd_state == R_IDLE && |m_arvalid)
            r_rd_gnt <= w_rd_pick;
      end
   end

   // Read FSM next state and channel muxing
   always_comb begin
      w_rd_nxt  = r_rd_state;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arlen   = '0;
      s_rready  = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      m_rlast   = '0;
      m_rdata   = '0;
      rd_owner  = '0;
      case (r_rd_state)
         R_IDLE: begin
            if (|m_arvalid)
               w_rd_nxt = R_AR;
         end
         R_AR: begin
            rd_owner[r_rd_gnt]  = 1'b1;
            s_arvalid           = m_arvalid[r_rd_gnt];
            s_araddr            = w_araddr_sel;
            s_arlen             = w_arlen_sel;
            m_arready[r_rd_gnt] = s_arready;
            if (m_arvalid[r_rd_gnt] && s_arready)
               w_rd_nxt = R_DATA;
         end
         R_DATA: begin
            rd_owner[r_rd_gnt] = 1'b1;
            m_rdata            = {2{s_rdata}};
            m_rlast            = {2{s_rlast}};
            m_rvalid[r_rd_gnt] = s_rvalid;
            s_rready           = m_rready[r_rd_gnt];
            if (s_rvalid && m_rready[r_rd_gnt] && s_rlast)
               w_rd_nxt = R_IDLE;
         end
         default: w_rd_nxt = R_IDLE;
      endcase
   end

endmodule
